pet_needs_fsm: RTL and testbench



---
 rtl/pet_pkg.sv | 33 +++
 rtl/pet_tick_gen.sv | 29 ++
 rtl/pet_needs_fsm.sv | 194 +++++++++++++++++++
 tb/tb_pet_needs_fsm.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared types and helpers for the virtual-pet needs machine.
//   state_t : FSM state codes driven on the state output
//   lvl_t   : 3-bit need level, 0..MAX_LVL
//   lvl_sat : applies a signed delta to a level, clamped to 0..max_lvl
package pet_pkg;

  localparam int unsigned LVL_W       = 3;
  localparam int unsigned DEF_MAX_LVL = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EAT   = 3'd1,
    S_BATH  = 3'd2,
    S_SLEEP = 3'd3,
    S_PLAY  = 3'd4,
    S_SICK  = 3'd5
  } state_t;

  typedef logic [LVL_W-1:0]        lvl_t;
  typedef logic signed [LVL_W:0]   delta_t;

  // All contributions are summed first, so clamping happens exactly once.
  function automatic lvl_t lvl_sat(input lvl_t lvl, input delta_t delta, input lvl_t max_lvl);
    logic signed [LVL_W+1:0] sum;
    sum = $signed({2'b00, lvl}) + $signed({delta[LVL_W], delta});
    if (sum < $signed((LVL_W+2)'(0)))
      return '0;
    if (sum > $signed({2'b00, max_lvl}))
      return max_lvl;
    return sum[LVL_W-1:0];
  endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Need-tick time base.
//   clk, reset : system clock, synchronous active-high reset
//   tick_c     : one-cycle pulse every TICK_CYCLES clocks (counter at its last value)
module pet_tick_gen #(
  parameter int unsigned TICK_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running 0..TICK_CYCLES-1 counter.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign tick_c = (cnt == LAST);

endmodule

// File: rtl/pet_needs_fsm.sv
// Virtual-pet state machine with four decaying, saturating need levels.
//   clk, reset          : system clock, synchronous active-high reset
//   eat                 : active-low feed button (falling edge = feed event)
//   bano, care          : bathing humidity, loneliness flag
//   distancia, frio     : play request, sustained cold
//   ouluz               : 1 = light, 0 = dark
//   state               : current state code (pet_pkg::state_t)
//   fullness, hygiene,
//   energy, happy       : need levels 0..MAX_LVL
//   alarm               : SICK or any level <= 1, one cycle late
//   state_chg           : one-cycle pulse the cycle after a state change
module pet_needs_fsm
  import pet_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter int unsigned DECAY_TICKS = 10,
  parameter int unsigned ACT_TICKS   = 3,
  parameter int unsigned SICK_TICKS  = 5,
  parameter int unsigned MAX_LVL     = DEF_MAX_LVL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       eat,
  input  logic       bano,
  input  logic       care,
  input  logic       distancia,
  input  logic       frio,
  input  logic       ouluz,
  output logic [2:0] state,
  output logic [2:0] fullness,
  output logic [2:0] hygiene,
  output logic [2:0] energy,
  output logic [2:0] happy,
  output logic       alarm,
  output logic       state_chg
);

  localparam int unsigned DEC_W  = $clog2(2 * DECAY_TICKS + 1);
  localparam int unsigned ACT_W  = $clog2(ACT_TICKS + 1);
  localparam int unsigned FRIO_W = $clog2(SICK_TICKS + 1);
  localparam lvl_t        MAXL   = lvl_t'(MAX_LVL);
  localparam lvl_t        LVL_LO = lvl_t'(1);
  localparam lvl_t        LVL_OK = lvl_t'(2);
  localparam delta_t      ONE    = delta_t'(1);
  localparam delta_t      TWO    = delta_t'(2);

  state_t             st;
  state_t             prev_st;
  state_t             nxt;
  logic               tick;
  logic               eat_prev;
  logic               feed;
  logic               sick_trig;
  logic               dec_fire;
  logic               hyg_fire;
  logic               act_done;
  logic [DEC_W-1:0]   dec_cnt;
  logic [DEC_W-1:0]   hyg_cnt;
  logic [ACT_W-1:0]   act_cnt;
  logic [FRIO_W-1:0]  frio_cnt;
  delta_t             d_full;
  delta_t             d_hyg;
  delta_t             d_hap;
  delta_t             d_eng;

  pet_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick_c(tick)
  );

  assign state     = st;
  assign feed      = eat_prev & ~eat;
  assign dec_fire  = tick && (dec_cnt == DEC_W'(DECAY_TICKS - 1));
  assign hyg_fire  = tick && (hyg_cnt == DEC_W'(2 * DECAY_TICKS - 1));
  assign act_done  = tick && (act_cnt == ACT_W'(ACT_TICKS - 1));
  assign sick_trig = (fullness == '0) || (hygiene == '0) ||
                     (frio_cnt == FRIO_W'(SICK_TICKS));

  // Next state; sickness preempts every other move.
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE: begin
        if (sick_trig)                       nxt = S_SICK;
        else if (feed)                       nxt = S_EAT;
        else if (bano && (hygiene != MAXL))  nxt = S_BATH;
        else if (!ouluz)                     nxt = S_SLEEP;
        else if (distancia && (energy != '0)) nxt = S_PLAY;
      end
      S_EAT: begin
        if (sick_trig)     nxt = S_SICK;
        else if (act_done) nxt = S_IDLE;
      end
      S_BATH: begin
        if (sick_trig)                      nxt = S_SICK;
        else if (!bano || (hygiene == MAXL)) nxt = S_IDLE;
      end
      S_SLEEP: begin
        if (sick_trig)  nxt = S_SICK;
        else if (ouluz) nxt = S_IDLE;
      end
      S_PLAY: begin
        if (sick_trig)                          nxt = S_SICK;
        else if (feed)                          nxt = S_EAT;
        else if (!distancia || (energy == '0))  nxt = S_IDLE;
      end
      S_SICK: begin
        if ((fullness >= LVL_OK) && (hygiene >= LVL_OK) && !frio) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Per-cycle level deltas: global decay plus the current state's rule.
  always_comb begin
    d_full = '0;
    d_hyg  = '0;
    d_hap  = '0;
    d_eng  = '0;
    if (dec_fire && (st != S_SLEEP)) begin
      d_full -= ONE;
      d_hap  -= ONE;
    end
    if (tick && care && (st != S_SLEEP))
      d_hap -= ONE;
    if (hyg_fire)
      d_hyg -= ONE;
    if (tick) begin
      case (st)
        S_IDLE:  if (dec_fire) d_eng -= ONE;
        S_BATH:  d_hyg += ONE;
        S_SLEEP: d_eng += ONE;
        S_PLAY: begin
          d_hap += ONE;
          d_eng -= ONE;
        end
        default: ;
      endcase
    end
    // Meal is credited on the entry cycle, tick or not.
    if ((nxt == S_EAT) && (st != S_EAT))
      d_full += TWO;
  end

  // State, levels, counters and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_IDLE;
      prev_st   <= S_IDLE;
      fullness  <= MAXL;
      hygiene   <= MAXL;
      energy    <= MAXL;
      happy     <= lvl_t'(3);
      alarm     <= 1'b0;
      state_chg <= 1'b0;
      eat_prev  <= 1'b1;
      dec_cnt   <= '0;
      hyg_cnt   <= '0;
      act_cnt   <= '0;
      frio_cnt  <= '0;
    end else begin
      st        <= nxt;
      prev_st   <= st;
      state_chg <= (st != prev_st);
      alarm     <= (st == S_SICK) || (fullness <= LVL_LO) || (hygiene <= LVL_LO) ||
                   (energy <= LVL_LO) || (happy <= LVL_LO);
      eat_prev  <= eat;
      fullness  <= lvl_sat(fullness, d_full, MAXL);
      hygiene   <= lvl_sat(hygiene,  d_hyg,  MAXL);
      energy    <= lvl_sat(energy,   d_eng,  MAXL);
      happy     <= lvl_sat(happy,    d_hap,  MAXL);

      if (tick) begin
        dec_cnt <= dec_fire ? '0 : dec_cnt + DEC_W'(1);
        hyg_cnt <= hyg_fire ? '0 : hyg_cnt + DEC_W'(1);
      end

      // Counts ticks spent in EAT; cleared whenever the pet is elsewhere.
      if (st != S_EAT)
        act_cnt <= '0;
      else if (tick)
        act_cnt <= act_cnt + ACT_W'(1);

      if (!frio)
        frio_cnt <= '0;
      else if (tick && (frio_cnt != FRIO_W'(SICK_TICKS)))
        frio_cnt <= frio_cnt + FRIO_W'(1);
    end
  end

endmodule

// File: tb/tb_pet_needs_fsm.sv
// Self-checking bench for pet_needs_fsm: hand-derived vector table,
// a short hand-written sequence, and randomized traffic against a model.
module tb_pet_needs_fsm;

  localparam int TC  = 4;
  localparam int DT  = 3;
  localparam int AT  = 2;
  localparam int STK = 4;
  localparam int MX  = 5;

  localparam int M_IDLE = 0, M_EAT = 1, M_BATH = 2, M_SLEEP = 3, M_PLAY = 4, M_SICK = 5;

  logic       clk;
  logic       reset;
  logic       eat, bano, care, distancia, frio, ouluz;
  logic [2:0] state, fullness, hygiene, energy, happy;
  logic       alarm, state_chg;

  int checks = 0;
  int errors = 0;

  pet_needs_fsm #(
    .TICK_CYCLES(TC),
    .DECAY_TICKS(DT),
    .ACT_TICKS  (AT),
    .SICK_TICKS (STK),
    .MAX_LVL    (MX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .eat      (eat),
    .bano     (bano),
    .care     (care),
    .distancia(distancia),
    .frio     (frio),
    .ouluz    (ouluz),
    .state    (state),
    .fullness (fullness),
    .hygiene  (hygiene),
    .energy   (energy),
    .happy    (happy),
    .alarm    (alarm),
    .state_chg(state_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Time is tracked as a cycle index since reset; ticks and decay moments
  // are derived arithmetically from that index.
  bit m_valid = 1'b0;
  int m_st, m_prev, m_full, m_hyg, m_eng, m_hap, m_alarm, m_chg;
  int m_n, m_eatp, m_fc, m_ticks, m_entry;

  function automatic int clampl(input int v);
    return (v < 0) ? 0 : ((v > MX) ? MX : v);
  endfunction

  always @(posedge clk) begin : model
    bit tk, dec, hdec, feed, sick;
    int k, nx, lo, df, dh, dhp, de;
    if (reset) begin
      m_valid = 1'b1;
      m_st = M_IDLE; m_prev = M_IDLE;
      m_full = MX; m_hyg = MX; m_eng = MX; m_hap = 3;
      m_alarm = 0; m_chg = 0;
      m_n = 0; m_eatp = 1; m_fc = 0; m_ticks = 0; m_entry = 0;
    end else if (m_valid) begin
      tk   = ((m_n % TC) == TC - 1);
      k    = m_n / TC + 1;
      dec  = tk && ((k % DT) == 0);
      hdec = tk && ((k % (2 * DT)) == 0);
      feed = (m_eatp == 1) && (eat == 1'b0);
      sick = (m_full == 0) || (m_hyg == 0) || (m_fc >= STK);
      nx = m_st;
      case (m_st)
        M_IDLE:  if (sick) nx = M_SICK; else if (feed) nx = M_EAT;
                 else if (bano && m_hyg < MX) nx = M_BATH; else if (!ouluz) nx = M_SLEEP;
                 else if (distancia && m_eng > 0) nx = M_PLAY;
        M_EAT:   if (sick) nx = M_SICK; else if (tk && (m_ticks + 1 - m_entry) >= AT) nx = M_IDLE;
        M_BATH:  if (sick) nx = M_SICK; else if (!bano || m_hyg == MX) nx = M_IDLE;
        M_SLEEP: if (sick) nx = M_SICK; else if (ouluz) nx = M_IDLE;
        M_PLAY:  if (sick) nx = M_SICK; else if (feed) nx = M_EAT;
                 else if (!distancia || m_eng == 0) nx = M_IDLE;
        default: if (m_full >= 2 && m_hyg >= 2 && !frio) nx = M_IDLE;
      endcase
      lo = m_full;
      if (m_hyg < lo) lo = m_hyg;
      if (m_eng < lo) lo = m_eng;
      if (m_hap < lo) lo = m_hap;
      m_alarm = (m_st == M_SICK || lo <= 1) ? 1 : 0;
      m_chg   = (m_st != m_prev) ? 1 : 0;
      df = 0; dh = 0; dhp = 0; de = 0;
      if (dec && m_st != M_SLEEP) begin df -= 1; dhp -= 1; end
      if (tk && care && m_st != M_SLEEP) dhp -= 1;
      if (hdec) dh -= 1;
      if (tk && m_st == M_IDLE && dec) de -= 1;
      if (tk && m_st == M_BATH) dh += 1;
      if (tk && m_st == M_SLEEP) de += 1;
      if (tk && m_st == M_PLAY) begin dhp += 1; de -= 1; end
      if (nx == M_EAT && m_st != M_EAT) begin
        df += 2;
        m_entry = m_ticks + (tk ? 1 : 0);
      end
      m_full = clampl(m_full + df);
      m_hyg  = clampl(m_hyg + dh);
      m_eng  = clampl(m_eng + de);
      m_hap  = clampl(m_hap + dhp);
      if (!frio) m_fc = 0;
      else if (tk && m_fc < STK) m_fc++;
      if (tk) m_ticks++;
      m_prev = m_st;
      m_st   = nx;
      m_eatp = eat ? 1 : 0;
      m_n++;
    end
  end

  // One clock, then compare every output with the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("model_state",     int'(state),     m_st);
      chk("model_fullness",  int'(fullness),  m_full);
      chk("model_hygiene",   int'(hygiene),   m_hyg);
      chk("model_energy",    int'(energy),    m_eng);
      chk("model_happy",     int'(happy),     m_hap);
      chk("model_alarm",     int'(alarm),     m_alarm);
      chk("model_state_chg", int'(state_chg), m_chg);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n;
    int rst, e, b, c, d, f, o;
    int st, full, hyg, eng, hap, al, chg;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input int n, input int r, input int e, input int b, input int c,
                              input int d, input int f, input int o, input int s, input int fu,
                              input int hy, input int en, input int ha, input int al, input int ch);
    vec_t v;
    v.n = n; v.rst = r; v.e = e; v.b = b; v.c = c; v.d = d; v.f = f; v.o = o;
    v.st = s; v.full = fu; v.hyg = hy; v.eng = en; v.hap = ha; v.al = al; v.chg = ch;
    return v;
  endfunction

  initial begin
    int hold, lat;
    bit found;
    reset = 1'b1; eat = 1'b1; bano = 1'b0; care = 1'b0;
    distancia = 1'b0; frio = 1'b0; ouluz = 1'b1;

    //            n  rst eat bano care dist frio luz | st fu hy en ha al chg
    vt.push_back(mk( 1, 1, 1, 0, 0, 0, 0, 1,   0, 5, 5, 5, 3, 0, 0)); // reset values
    vt.push_back(mk(36, 0, 1, 0, 0, 0, 0, 1,   0, 2, 4, 2, 0, 1, 0)); // 9 idle ticks
    vt.push_back(mk(12, 0, 1, 0, 0, 0, 0, 1,   0, 1, 3, 1, 0, 1, 0)); // happy clamps at 0
    vt.push_back(mk( 2, 0, 1, 0, 0, 1, 0, 1,   4, 1, 3, 1, 0, 1, 1)); // play with energy 1
    vt.push_back(mk( 4, 0, 1, 0, 0, 1, 0, 1,   0, 1, 3, 0, 1, 1, 1)); // energy 0, no re-entry
    vt.push_back(mk( 1, 1, 1, 0, 0, 0, 0, 1,   0, 5, 5, 5, 3, 0, 0));
    vt.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 1,   1, 5, 5, 5, 3, 0, 0)); // feed, fullness saturates
    vt.push_back(mk( 1, 0, 1, 0, 0, 0, 0, 1,   1, 5, 5, 5, 3, 0, 1)); // state_chg pulse
    vt.push_back(mk( 5, 0, 1, 0, 0, 0, 0, 1,   1, 5, 5, 5, 3, 0, 0));
    vt.push_back(mk( 1, 0, 1, 0, 0, 0, 0, 1,   0, 5, 5, 5, 3, 0, 0)); // back after 2 ticks
    vt.push_back(mk( 1, 0, 1, 0, 0, 0, 0, 1,   0, 5, 5, 5, 3, 0, 1));
    vt.push_back(mk(15, 0, 1, 0, 0, 0, 0, 1,   0, 3, 4, 3, 1, 0, 0));
    vt.push_back(mk( 1, 0, 1, 1, 0, 0, 0, 0,   2, 3, 4, 3, 1, 1, 0)); // bath beats sleep
    vt.push_back(mk( 3, 0, 1, 1, 0, 0, 0, 0,   2, 3, 5, 3, 1, 1, 0));
    vt.push_back(mk( 1, 0, 1, 1, 0, 0, 0, 0,   0, 3, 5, 3, 1, 1, 0)); // hygiene full, exit
    vt.push_back(mk( 1, 0, 1, 1, 0, 0, 0, 0,   3, 3, 5, 3, 1, 1, 1)); // then sleep
    vt.push_back(mk(14, 0, 1, 0, 0, 0, 1, 0,   3, 3, 5, 5, 1, 1, 0)); // 4 cold ticks asleep
    vt.push_back(mk( 1, 0, 1, 0, 0, 0, 1, 0,   5, 3, 5, 5, 1, 1, 0)); // sick
    vt.push_back(mk( 1, 0, 1, 0, 0, 0, 0, 1,   0, 3, 5, 5, 1, 1, 1)); // recovered
    vt.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 1,   1, 5, 5, 5, 1, 1, 1)); // feed +2
    vt.push_back(mk( 1, 1, 1, 0, 0, 0, 0, 1,   0, 5, 5, 5, 3, 0, 0)); // reset mid-EAT

    for (int i = 0; i < vt.size(); i++) begin
      reset = (vt[i].rst != 0); eat = (vt[i].e != 0); bano = (vt[i].b != 0);
      care = (vt[i].c != 0); distancia = (vt[i].d != 0); frio = (vt[i].f != 0);
      ouluz = (vt[i].o != 0);
      repeat (vt[i].n) cycle();
      chk($sformatf("row%0d_state", i),     int'(state),     vt[i].st);
      chk($sformatf("row%0d_fullness", i),  int'(fullness),  vt[i].full);
      chk($sformatf("row%0d_hygiene", i),   int'(hygiene),   vt[i].hyg);
      chk($sformatf("row%0d_energy", i),    int'(energy),    vt[i].eng);
      chk($sformatf("row%0d_happy", i),     int'(happy),     vt[i].hap);
      chk($sformatf("row%0d_alarm", i),     int'(alarm),     vt[i].al);
      chk($sformatf("row%0d_state_chg", i), int'(state_chg), vt[i].chg);
    end

    // Feed while asleep is ignored; wake-up on light within one cycle.
    reset = 1'b0; eat = 1'b1; ouluz = 1'b0;
    cycle();
    eat = 1'b0;
    cycle();
    eat = 1'b1;
    cycle();
    chk("sleep_feed_state", int'(state), M_SLEEP);
    chk("sleep_feed_fullness", int'(fullness), MX);
    ouluz = 1'b1;
    found = 1'b0; lat = 0;
    for (int w = 1; w <= 20 && !found; w++) begin
      cycle();
      if (int'(state) == M_IDLE) begin found = 1'b1; lat = w; end
    end
    chk("wake_seen", int'(found), 1);
    chk("wake_latency", lat, 1);

    // Randomized traffic; inputs held for short random stretches.
    repeat (400) begin
      hold      = $urandom_range(1, 16);
      reset     = ($urandom_range(0, 39) == 0);
      bano      = ($urandom_range(0, 3) == 0);
      care      = ($urandom_range(0, 3) == 0);
      distancia = ($urandom_range(0, 2) == 0);
      frio      = ($urandom_range(0, 4) == 0);
      ouluz     = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < hold; j++) begin
        eat = ($urandom_range(0, 9) != 0);
        cycle();
        reset = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
